// File: rtl/can_rx_destuff.sv
// CAN receive destuffer: bus integration, SOF detection, stuff-bit removal and running CRC-15.
// Optional CAN_RX_HARD_SYNC_EN adds a combinational hard_sync strobe on the SOF edge.
module can_rx_destuff #(
  parameter int unsigned IDLE_BITS = 11,
  parameter int unsigned STUFF_LEN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic        rx_bit,
  input  logic        stuff_en,
  input  logic        frame_end,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        sof,
  output logic        stuff_err,
  output logic        bus_idle,
  output logic [14:0] crc_reg,
`ifdef CAN_RX_HARD_SYNC_EN
  output logic        hard_sync,
`endif
  output logic        crc_zero
);

  localparam int unsigned IDLE_W = 4;
  localparam int unsigned RUN_W  = 3;
  localparam int unsigned CRC_W  = 15;

  localparam logic [1:0] ST_INTEGRATE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_FRAME     = 2'd2;

  localparam logic [CRC_W-1:0]  CRC_POLY = 15'h4599;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_BITS);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);

  logic [1:0]        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              last_bit_q, last_bit_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              sof_q, sof_d;
  logic              stuff_err_q, stuff_err_d;
  logic              bus_idle_q;
  logic              crc_zero_q;

  // One serial CRC-15 step, MSB-first.
  function automatic logic [CRC_W-1:0] crc_shift(input logic [CRC_W-1:0] c, input logic b);
    logic nxt;
    nxt       = b ^ c[CRC_W-1];
    crc_shift = {c[CRC_W-2:0], 1'b0} ^ (nxt ? CRC_POLY : '0);
  endfunction

  assign idle_inc = (idle_cnt_q >= IDLE_MAX) ? IDLE_MAX : idle_cnt_q + IDLE_W'(1);

  // Next-state and output decode; frame_end pre-empts a coincident sample.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    run_cnt_d   = run_cnt_q;
    last_bit_d  = last_bit_q;
    crc_d       = crc_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;

    if (state_q == ST_FRAME && frame_end) begin
      state_d    = ST_INTEGRATE;
      idle_cnt_d = '0;
    end else if (sample_en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (rx_bit) begin
            idle_cnt_d = idle_inc;
            if (idle_inc == IDLE_MAX) state_d = ST_IDLE;
          end else begin
            idle_cnt_d = '0;
          end
        end
        ST_IDLE: begin
          if (!rx_bit) begin
            state_d     = ST_FRAME;
            bit_valid_d = 1'b1;
            sof_d       = 1'b1;
            bit_out_d   = 1'b0;
            run_cnt_d   = RUN_W'(1);
            last_bit_d  = 1'b0;
            crc_d       = crc_shift('0, 1'b0);
          end
        end
        ST_FRAME: begin
          if (stuff_en) begin
            if (run_cnt_q == RUN_MAX) begin
              if (rx_bit != last_bit_q) begin
                run_cnt_d  = RUN_W'(1);
                last_bit_d = rx_bit;
              end else begin
                stuff_err_d = 1'b1;
                state_d     = ST_INTEGRATE;
                idle_cnt_d  = '0;
              end
            end else begin
              bit_valid_d = 1'b1;
              bit_out_d   = rx_bit;
              crc_d       = crc_shift(crc_q, rx_bit);
              run_cnt_d   = (rx_bit == last_bit_q) ? run_cnt_q + RUN_W'(1) : RUN_W'(1);
              last_bit_d  = rx_bit;
            end
          end else begin
            bit_valid_d = 1'b1;
            bit_out_d   = rx_bit;
            run_cnt_d   = RUN_W'(1);
            last_bit_d  = rx_bit;
          end
        end
        default: begin
          state_d    = ST_INTEGRATE;
          idle_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INTEGRATE;
      idle_cnt_q  <= '0;
      run_cnt_q   <= '0;
      last_bit_q  <= 1'b1;
      crc_q       <= '0;
      bit_out_q   <= 1'b1;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      bus_idle_q  <= 1'b0;
      crc_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      run_cnt_q   <= run_cnt_d;
      last_bit_q  <= last_bit_d;
      crc_q       <= crc_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      stuff_err_q <= stuff_err_d;
      bus_idle_q  <= (state_d == ST_IDLE);
      crc_zero_q  <= (crc_d == '0);
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign sof       = sof_q;
  assign stuff_err = stuff_err_q;
  assign bus_idle  = bus_idle_q;
  assign crc_reg   = crc_q;
  assign crc_zero  = crc_zero_q;

`ifdef CAN_RX_HARD_SYNC_EN
  // Falling edge of the raw bus level while idle restarts the bit timer.
  logic rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_prev_q <= 1'b1;
    else       rx_prev_q <= rx_bit;
  end

  assign hard_sync = (state_q == ST_IDLE) && rx_prev_q && !rx_bit;
`endif

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed self-checking bench for can_rx_destuff.
module tb_can_rx_destuff;

  logic        clk = 1'b0;
  logic        reset, sample_en, rx_bit, stuff_en, frame_end;
  logic        bit_out, bit_valid, sof, stuff_err, bus_idle, crc_zero;
  logic [14:0] crc_reg;
`ifdef CAN_RX_HARD_SYNC_EN
  logic        hard_sync;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic        obs_valid, obs_out, obs_sof, obs_err, obs_idle, obs_zero;
  logic [14:0] obs_crc;

  bit exp_q[$];
  bit tx_q[$];
  bit txs_q[$];

  can_rx_destuff dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .rx_bit    (rx_bit),
    .stuff_en  (stuff_en),
    .frame_end (frame_end),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .sof       (sof),
    .stuff_err (stuff_err),
    .bus_idle  (bus_idle),
    .crc_reg   (crc_reg),
`ifdef CAN_RX_HARD_SYNC_EN
    .hard_sync (hard_sync),
`endif
    .crc_zero  (crc_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sample_en cycle, capture registered outputs, then one quiet cycle.
  task automatic send(input logic b);
    rx_bit    = b;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    obs_valid = bit_valid;
    obs_out   = bit_out;
    obs_sof   = sof;
    obs_err   = stuff_err;
    obs_idle  = bus_idle;
    obs_crc   = crc_reg;
    obs_zero  = crc_zero;
    @(posedge clk); #1;
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    for (int i = 0; i < 10; i++) send(1'b1);
    check({tag, "_pre"}, obs_idle, 0);
    send(1'b1);
    check(tag, obs_idle, 1);
  endtask

  // Unstuffed frame into exp_q, stuffed line bits into tx_q (txs_q marks stuff bits).
  task automatic build_frame(input bit flip);
    logic [26:0] hdr;
    logic [14:0] c;
    logic        nxt;
    bit          last;
    int          run;
    hdr = {1'b0, 11'h123, 3'b000, 4'h1, 8'hA5};
    c   = '0;
    exp_q.delete(); tx_q.delete(); txs_q.delete();
    for (int i = 26; i >= 0; i--) begin
      exp_q.push_back(hdr[i]);
      nxt = hdr[i] ^ c[14];
      c   = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) exp_q.push_back(c[i]);
    if (flip) exp_q[33] = ~exp_q[33];
    run  = 0;
    last = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0 || exp_q[i] != last) run = 1;
      else run++;
      last = exp_q[i];
      tx_q.push_back(exp_q[i]); txs_q.push_back(1'b0);
      if (run == 5) begin
        tx_q.push_back(~last); txs_q.push_back(1'b1);
        last = ~last;
        run  = 1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input bit flip);
    int k;
    int errs;
    build_frame(flip);
    stuff_en = 1'b1;
    k    = 0;
    errs = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      send(tx_q[i]);
      if (obs_valid !== !txs_q[i]) begin
        errs++;
        check({tag, "_valid"}, obs_valid, !txs_q[i]);
      end
      if (obs_valid === 1'b1 && k < exp_q.size()) begin
        if (obs_out !== exp_q[k]) check({tag, "_bit"}, obs_out, exp_q[k]);
        k++;
      end
      if (obs_err !== 1'b0) check({tag, "_stuff_err"}, obs_err, 0);
    end
    check({tag, "_count"}, k, exp_q.size());
    check({tag, "_stuff_bits"}, tx_q.size() - exp_q.size() > 0, 1);
    check({tag, "_crc_zero"}, obs_zero, flip ? 0 : 1);
    if (!flip) check({tag, "_crc_reg"}, obs_crc, 0);
    pulse_end();
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; rx_bit = 1'b1; stuff_en = 1'b0; frame_end = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_bus_idle", bus_idle, 0);
    check("rst_bit_out", bit_out, 1);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_sof", sof, 0);
    check("rst_stuff_err", stuff_err, 0);
    check("rst_crc_reg", crc_reg, 0);

    // 10 recessive then dominant: no idle
    for (int i = 0; i < 10; i++) send(1'b1);
    check("int10_idle", obs_idle, 0);
    check("int10_valid", obs_valid, 0);
    send(1'b0);
    check("int_dom_idle", obs_idle, 0);
    go_idle("int11_idle");

    // SOF + 4 zeros, stuff bit, then a data zero
    stuff_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b0);
      check("seq_valid", obs_valid, 1);
      check("seq_sof", obs_sof, i == 0);
      check("seq_out", obs_out, 0);
      check("seq_err", obs_err, 0);
    end
    check("seq_idle_drop", obs_idle, 0);
    send(1'b1);
    check("seq_stuff_valid", obs_valid, 0);
    check("seq_stuff_err", obs_err, 0);
    send(1'b0);
    check("seq7_valid", obs_valid, 1);
    check("seq7_out", obs_out, 0);
    check("seq7_err", obs_err, 0);
    pulse_end();

    // six dominant bits -> stuff error
    go_idle("se_idle");
    for (int i = 0; i < 5; i++) send(1'b0);
    check("se5_err", obs_err, 0);
    send(1'b0);
    check("se6_err", obs_err, 1);
    check("se6_valid", obs_valid, 0);
    check("se6_idle", obs_idle, 0);
    go_idle("se_reidle");

    // full stuffed frame, good then corrupted CRC
    run_frame("frm_ok", 1'b0);
    go_idle("frm_reidle");
    run_frame("frm_bad", 1'b1);

    // stuff_en low: 8 recessive all pass through
    go_idle("ns_idle");
    send(1'b0);
    check("ns_sof", obs_sof, 1);
    stuff_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      check("ns_valid", obs_valid, 1);
      check("ns_out", obs_out, 1);
      check("ns_err", obs_err, 0);
    end
    check("ns_crc", obs_crc, 0);

    // frame_end coincident with sample_en
    rx_bit = 1'b0; sample_en = 1'b1; frame_end = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0; frame_end = 1'b0;
    check("fe_valid", bit_valid, 0);
    check("fe_idle", bus_idle, 0);
    @(posedge clk); #1;
    go_idle("fe_reidle");

    // asynchronous reset mid-frame
    stuff_en = 1'b1;
    send(1'b0);
    rx_bit = 1'b1; sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    check("pre_rst_valid", bit_valid, 1);
    check("pre_rst_crc_nz", crc_reg != 15'h0, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_bit_out", bit_out, 1);
    check("mid_rst_crc", crc_reg, 0);
    check("mid_rst_zero", crc_zero, 1);
    check("mid_rst_idle", bus_idle, 0);
    @(posedge clk); #1 reset = 1'b0;
    go_idle("post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_rx_destuff.md
Name: can_rx_destuff

Overview:
- Receive-path stage directly downstream of the CAN bit-timing block.
- Consumes one sampled bus bit per bit time and performs bus-integration (idle detection) and SOF detection.
- Removes stuff bits, flags stuff errors, and hands destuffed bits to the frame decoder with a one-cycle valid strobe.
- Keeps a running CRC-15 over the destuffed bits.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required to declare the bus idle (range 1-15).
- STUFF_LEN, 5, run length of equal bits after which a complementary stuff bit is expected (range 2-7).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_en  in  1  one-clk strobe per bit time from bit timing; qualifies rx_bit
- rx_bit  in  1  sampled bus level (1 = recessive, 0 = dominant)
- stuff_en  in  1  from frame decoder: stuff rule active (SOF through CRC field); sampled only on sample_en
- frame_end  in  1  one-clk pulse from decoder: frame finished or aborted; return to integration
- bit_out  out  1  destuffed bit
- bit_valid  out  1  one-clk strobe, bit_out is valid
- sof  out  1  one-clk strobe coincident with bit_valid of the SOF bit
- stuff_err  out  1  one-clk strobe, 6th equal bit seen while stuff_en=1
- bus_idle  out  1  level, high in IDLE state
- crc_reg  out  15  running CRC-15 remainder
- crc_zero  out  1  level, crc_reg == 0

Behaviour:
- Reset: state=INTEGRATE; idle/run counters=0; last_bit=1; crc_reg=0; bit_out=1; all strobes=0; bus_idle=0.
- All state updates occur only on clk edges where sample_en=1, except that a frame_end pulse is acted on in any cycle.
- Outputs are registered: bit_valid, sof and stuff_err assert exactly 1 clk after the qualifying sample_en cycle.
- INTEGRATE state:
  - rx_bit=1 increments idle_cnt; rx_bit=0 clears it to 0.
  - When idle_cnt reaches IDLE_BITS, go to IDLE.
  - No bit_valid is issued in this state.
- IDLE state:
  - bus_idle=1.
  - rx_bit=1: stay in IDLE.
  - rx_bit=0: this is SOF. Go to FRAME; emit bit_valid=1, sof=1, bit_out=0; set run_cnt=1, last_bit=0.
  - The CRC is cleared to 0, then the SOF bit is shifted in.
- FRAME state, stuff_en=1:
  - If run_cnt==STUFF_LEN and rx_bit!=last_bit: the bit is a stuff bit. It is dropped (no bit_valid, no CRC update). Set run_cnt=1, last_bit=rx_bit.
  - If run_cnt==STUFF_LEN and rx_bit==last_bit: pulse stuff_err and go to INTEGRATE with idle_cnt=0. No bit_valid is issued.
  - Otherwise: emit the bit with bit_valid and shift it into the CRC. If rx_bit==last_bit, run_cnt increments; else run_cnt=1. Set last_bit=rx_bit.
- FRAME state, stuff_en=0:
  - Every bit is passed through with bit_valid; the CRC is not updated.
  - run_cnt=1 and last_bit tracks rx_bit, so that re-enabling stuffing starts a fresh run.
- frame_end while in FRAME: go to INTEGRATE with idle_cnt=0.
- frame_end and a sample_en in the same clk:
  - frame_end wins; the sample is not processed.
  - crc_reg holds its value until the next SOF.
- CRC-15:
  - Polynomial 0x4599.
  - Per shifted bit b: nxt = b ^ crc[14]; crc = {crc[13:0],1'b0}; if nxt, crc ^= 0x4599.
  - Feeding the received CRC field leaves crc_reg=0 for an error-free frame.
- Counter widths: idle_cnt 4 bits, saturating at IDLE_BITS; run_cnt 3 bits.
- Reset asserted mid-frame: immediately return to reset values; bus integration restarts.

Optional Feature:
- Macro: CAN_RX_HARD_SYNC_EN.
- Defined: adds output hard_sync (1 bit). It is a one-clk strobe generated combinationally when state=IDLE and rx_bit transitions 1->0, independent of sample_en. The bit-timing block uses it to restart its bit-time counter on the SOF edge.
- Not defined: the port is absent and there is no extra logic.

Test Plan:
- Reset, then 11 recessive samples -> bus_idle rises 1 clk after the 11th sample_en. 10 recessive followed by 1 dominant -> bus_idle stays 0.
- Idle bus, then rx sequence 0,0,0,0,0,1,0 with stuff_en=1:
  - bits 1-5 each give bit_valid, with sof only on the first.
  - the 6th bit (1) gives no bit_valid.
  - the 7th gives bit_valid with bit_out=0.
  - stuff_err stays 0.
- Idle, SOF, then 5 more dominant bits with stuff_en=1 (6 zeros total) -> stuff_err pulses once after the 6th zero; next state INTEGRATE; bus_idle=0 until 11 recessive bits.
- Full frame (ID 0x123, DLC 1, data 0xA5, correct CRC, stuffed) with stuff_en high through the CRC field -> destuffed stream matches the unstuffed frame bit-for-bit; crc_zero=1 after the last CRC bit. The same frame with one CRC bit flipped -> crc_zero=0.
- stuff_en=0 with 8 consecutive recessive bits -> 8 bit_valid strobes and no stuff_err.
- frame_end asserted in the same clk as sample_en mid-frame -> no bit_valid for that sample; state INTEGRATE. Reset asserted mid-frame -> all outputs return to reset values in the same cycle.
